// File: rtl/sgmii_seq_pkg.sv
// Shared types for the SGMII link sequencer: state encoding and bit indices
// into the PCS status vector and the synchroniser bus.
package sgmii_seq_pkg;

  typedef enum logic [3:0] {
    PHY_RST   = 4'd0,
    PHY_WAIT  = 4'd1,
    PMA_RST   = 4'd2,
    WAIT_DONE = 4'd3,
    WAIT_LOCK = 4'd4,
    WAIT_LINK = 4'd5,
    UP        = 4'd6,
    RETRY     = 4'd7,
    FAIL      = 4'd8
  } seq_state_t;

  // Bit positions inside status_vector
  localparam int STS_LINK = 0;
  localparam int STS_SYNC = 1;

  // Layout of the synchroniser bus
  localparam int SYNC_W   = 4;
  localparam int SYN_DONE = 0;
  localparam int SYN_LOCK = 1;
  localparam int SYN_LINK = 2;
  localparam int SYN_SYNC = 3;

endpackage

// File: rtl/sgmii_seq_sync.sv
// Parameterised-width two-flop synchroniser used to bring the GT, MMCM and
// PCS status signals into the sys0_clk domain. Adds two cycles of latency.
module sgmii_seq_sync
  import sgmii_seq_pkg::*;
#(
  parameter int WIDTH = SYNC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sgmii_link_sequencer.sv
// Bring-up / recovery sequencer for the SGMII path (external PHY, GT PCS/PMA,
// txoutclk MMCM). Walks PHY reset, PMA reset, MMCM reset and PCS reset in
// order, qualifies the link from status_vector and retries on timeout.
// Optional build macro SGMII_LINK_SEQ_STATS_EN enables the link_drops counter.
module sgmii_link_sequencer
  import sgmii_seq_pkg::*;
#(
  parameter int PHY_RST_CYC     = 2000,
  parameter int PHY_WAIT_CYC    = 1000000,
  parameter int PMA_RST_CYC     = 4,
  parameter int TIMEOUT_CYC     = 4000000,
  parameter int LINK_STABLE_CYC = 2000,
  parameter int MAX_RETRY       = 4,
  parameter int TMR_W           = 24
) (
  input  logic        i_sys0_clk,
  input  logic        i_sys0_rst,
  input  logic        i_restart,
  input  logic        i_resetdone,
  input  logic        i_mmcm_locked,
  input  logic [15:0] i_status_vector,
  output logic        o_gmii_rstn,
  output logic        o_pma_reset,
  output logic        o_mmcm_reset,
  output logic        o_pcs_reset,
  output logic        o_link_up,
  output logic        o_fail,
  output logic [3:0]  o_retry_cnt,
  output logic [3:0]  o_seq_state,
  output logic [15:0] o_link_drops
);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timerNext;
  logic [TMR_W-1:0] r_stable;
  logic [TMR_W-1:0] w_stableNext;
  logic [3:0]       r_retryCnt;
  logic [3:0]       w_retryNext;
  logic             r_gmiiRstn, r_pmaReset, r_mmcmReset, r_pcsReset, r_linkUp, r_fail;
  logic             w_gmiiRstnNext, w_pmaResetNext, w_mmcmResetNext, w_pcsResetNext;
  logic             w_linkUpNext, w_failNext;
  logic             w_load, w_expired, w_linkOk, w_dropEvent;
  logic [SYNC_W-1:0] w_async;
  logic [SYNC_W-1:0] w_sync;

  assign w_async[SYN_DONE] = i_resetdone;
  assign w_async[SYN_LOCK] = i_mmcm_locked;
  assign w_async[SYN_LINK] = i_status_vector[STS_LINK];
  assign w_async[SYN_SYNC] = i_status_vector[STS_SYNC];

  sgmii_seq_sync #(.WIDTH(SYNC_W)) u_sync (
    .i_clk   (i_sys0_clk),
    .i_rst   (i_sys0_rst),
    .i_async (w_async),
    .o_sync  (w_sync)
  );

  assign w_linkOk  = w_sync[SYN_LINK] & w_sync[SYN_SYNC];
  assign w_expired = (r_timer == TMR_W'(1));

  // Next-state, counters and registered output values; restart overrides everything
  always_comb begin
    w_nextState     = r_state;
    w_load          = 1'b0;
    w_retryNext     = r_retryCnt;
    w_failNext      = r_fail;
    w_dropEvent     = 1'b0;
    w_timerNext     = r_timer;
    w_stableNext    = r_stable;
    w_gmiiRstnNext  = r_gmiiRstn;
    w_pmaResetNext  = r_pmaReset;
    w_mmcmResetNext = r_mmcmReset;
    w_pcsResetNext  = r_pcsReset;
    w_linkUpNext    = r_linkUp;

    if (i_restart) begin
      w_nextState = PHY_RST;
      w_retryNext = 4'd0;
      w_failNext  = 1'b0;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        PHY_RST:   if (w_expired) w_nextState = PHY_WAIT;
        PHY_WAIT:  if (w_expired) w_nextState = PMA_RST;
        PMA_RST:   if (w_expired) w_nextState = WAIT_DONE;
        WAIT_DONE: begin
          if (w_sync[SYN_DONE])  w_nextState = WAIT_LOCK;
          else if (w_expired)    w_nextState = RETRY;
        end
        WAIT_LOCK: begin
          if (w_sync[SYN_LOCK])  w_nextState = WAIT_LINK;
          else if (w_expired)    w_nextState = RETRY;
        end
        WAIT_LINK: begin
          if (w_linkOk && (r_stable == TMR_W'(1))) w_nextState = UP;
          else if (w_expired)                       w_nextState = RETRY;
        end
        UP: begin
          if (!w_sync[SYN_LOCK] || !w_sync[SYN_DONE]) begin
            w_nextState = RETRY;
            w_dropEvent = 1'b1;
          end else if (!w_linkOk) begin
            w_nextState = WAIT_LINK;
            w_dropEvent = 1'b1;
          end
        end
        RETRY: begin
          w_retryNext = r_retryCnt + 4'd1;
          w_nextState = (w_retryNext == 4'(MAX_RETRY)) ? FAIL : PHY_RST;
        end
        FAIL:      w_nextState = FAIL;
        default:   w_nextState = PHY_RST;
      endcase
      if (w_nextState != r_state) w_load = 1'b1;
    end

    if (w_load) begin
      case (w_nextState)
        PHY_RST:   w_timerNext = TMR_W'(PHY_RST_CYC);
        PHY_WAIT:  w_timerNext = TMR_W'(PHY_WAIT_CYC);
        PMA_RST:   w_timerNext = TMR_W'(PMA_RST_CYC);
        WAIT_DONE,
        WAIT_LOCK,
        WAIT_LINK: w_timerNext = TMR_W'(TIMEOUT_CYC);
        default:   w_timerNext = '0;
      endcase
    end else if (r_timer != '0) begin
      w_timerNext = r_timer - TMR_W'(1);
    end

    if ((w_nextState == WAIT_LINK) && ((r_state != WAIT_LINK) || !w_linkOk)) begin
      w_stableNext = TMR_W'(LINK_STABLE_CYC);
    end else if ((r_state == WAIT_LINK) && w_linkOk && (r_stable != '0)) begin
      w_stableNext = r_stable - TMR_W'(1);
    end

    case (w_nextState)
      PHY_RST: begin
        w_gmiiRstnNext  = 1'b0;
        w_pmaResetNext  = 1'b1;
        w_mmcmResetNext = 1'b1;
        w_pcsResetNext  = 1'b1;
        w_linkUpNext    = 1'b0;
      end
      PHY_WAIT:  w_gmiiRstnNext  = 1'b1;
      PMA_RST:   w_pmaResetNext  = 1'b1;
      WAIT_DONE: w_pmaResetNext  = 1'b0;
      WAIT_LOCK: w_mmcmResetNext = 1'b0;
      WAIT_LINK: begin
        w_pcsResetNext = 1'b0;
        w_linkUpNext   = 1'b0;
      end
      UP:        w_linkUpNext    = 1'b1;
      RETRY:     w_linkUpNext    = 1'b0;
      FAIL: begin
        w_failNext      = 1'b1;
        w_gmiiRstnNext  = 1'b0;
        w_pmaResetNext  = 1'b1;
        w_mmcmResetNext = 1'b1;
        w_pcsResetNext  = 1'b1;
        w_linkUpNext    = 1'b0;
      end
      default: ;
    endcase
  end

  // State, timers and all outputs are registered together
  always_ff @(posedge i_sys0_clk) begin
    if (i_sys0_rst) begin
      r_state     <= PHY_RST;
      r_timer     <= TMR_W'(PHY_RST_CYC);
      r_stable    <= TMR_W'(LINK_STABLE_CYC);
      r_retryCnt  <= 4'd0;
      r_gmiiRstn  <= 1'b0;
      r_pmaReset  <= 1'b1;
      r_mmcmReset <= 1'b1;
      r_pcsReset  <= 1'b1;
      r_linkUp    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_timer     <= w_timerNext;
      r_stable    <= w_stableNext;
      r_retryCnt  <= w_retryNext;
      r_gmiiRstn  <= w_gmiiRstnNext;
      r_pmaReset  <= w_pmaResetNext;
      r_mmcmReset <= w_mmcmResetNext;
      r_pcsReset  <= w_pcsResetNext;
      r_linkUp    <= w_linkUpNext;
      r_fail      <= w_failNext;
    end
  end

`ifdef SGMII_LINK_SEQ_STATS_EN
  logic [15:0] r_linkDrops;
  logic        w_unused;

  assign w_unused = ^i_status_vector[15:2];

  // Saturating count of link losses seen from UP; only sys0_rst clears it
  always_ff @(posedge i_sys0_clk) begin
    if (i_sys0_rst) begin
      r_linkDrops <= 16'h0000;
    end else if (w_dropEvent && !i_restart && (r_linkDrops != 16'hFFFF)) begin
      r_linkDrops <= r_linkDrops + 16'd1;
    end
  end

  assign o_link_drops = r_linkDrops;
`else
  logic w_unused;

  assign w_unused     = ^{i_status_vector[15:2], w_dropEvent};
  assign o_link_drops = 16'h0000;
`endif

  assign o_gmii_rstn  = r_gmiiRstn;
  assign o_pma_reset  = r_pmaReset;
  assign o_mmcm_reset = r_mmcmReset;
  assign o_pcs_reset  = r_pcsReset;
  assign o_link_up    = r_linkUp;
  assign o_fail       = r_fail;
  assign o_retry_cnt  = r_retryCnt;
  assign o_seq_state  = r_state;

endmodule

// File: tb/tb_sgmii_link_sequencer.sv
// Directed bench for sgmii_link_sequencer with shortened timing parameters.
// Cycle N is the interval following the N-th rising edge after reset release;
// outputs are sampled 1 time unit after that edge.
module tb_sgmii_link_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        resetdone = 1'b0;
  logic        locked = 1'b0;
  logic [15:0] status = 16'h0000;
  logic        gmiiRstn, pmaReset, mmcmReset, pcsReset, linkUp, failOut;
  logic [3:0]  retryCnt, seqState;
  logic [15:0] linkDrops;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef SGMII_LINK_SEQ_STATS_EN
  localparam logic [15:0] DROPS_AFTER_FLAP = 16'd1;
  localparam logic [15:0] DROPS_AFTER_LOSS = 16'd2;
`else
  localparam logic [15:0] DROPS_AFTER_FLAP = 16'd0;
  localparam logic [15:0] DROPS_AFTER_LOSS = 16'd0;
`endif

  sgmii_link_sequencer #(
    .PHY_RST_CYC     (8),
    .PHY_WAIT_CYC    (16),
    .PMA_RST_CYC     (4),
    .TIMEOUT_CYC     (64),
    .LINK_STABLE_CYC (8),
    .MAX_RETRY       (3),
    .TMR_W           (24)
  ) dut (
    .i_sys0_clk      (clk),
    .i_sys0_rst      (rst),
    .i_restart       (restart),
    .i_resetdone     (resetdone),
    .i_mmcm_locked   (locked),
    .i_status_vector (status),
    .o_gmii_rstn     (gmiiRstn),
    .o_pma_reset     (pmaReset),
    .o_mmcm_reset    (mmcmReset),
    .o_pcs_reset     (pcsReset),
    .o_link_up       (linkUp),
    .o_fail          (failOut),
    .o_retry_cnt     (retryCnt),
    .o_seq_state     (seqState),
    .o_link_drops    (linkDrops)
  );

  // Free-running 100 MHz-style clock
  always #5 clk = ~clk;

  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic applyStimulus(input logic done, input logic lock, input logic [15:0] sts);
    resetdone = done;
    locked    = lock;
    status    = sts;
  endtask

  task automatic doReset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    doReset();
    checks++; if (seqState !== 4'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", seqState); end
    checks++; if (gmiiRstn !== 1'b0) begin errors++; $display("[TB] FAIL reset_gmii_rstn: got %b expected 0", gmiiRstn); end
    checks++; if ({pmaReset, mmcmReset, pcsReset} !== 3'b111) begin errors++; $display("[TB] FAIL reset_resets: got %b expected 111", {pmaReset, mmcmReset, pcsReset}); end
    checks++; if (linkUp !== 1'b0 || failOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_link_fail: got %b%b expected 00", linkUp, failOut); end
    checks++; if (retryCnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_retry: got %0d expected 0", retryCnt); end
    checks++; if (linkDrops !== 16'd0) begin errors++; $display("[TB] FAIL reset_drops: got %0d expected 0", linkDrops); end
  endtask

  task automatic test_bring_up;
    stepTo(7);
    checks++; if (gmiiRstn !== 1'b0 || seqState !== 4'd0) begin errors++; $display("[TB] FAIL phy_rst_end: got gmii=%b st=%0d expected gmii=0 st=0", gmiiRstn, seqState); end
    stepTo(8);
    checks++; if (gmiiRstn !== 1'b1 || seqState !== 4'd1) begin errors++; $display("[TB] FAIL gmii_rise: got gmii=%b st=%0d expected gmii=1 st=1", gmiiRstn, seqState); end
    stepTo(23);
    checks++; if (seqState !== 4'd1) begin errors++; $display("[TB] FAIL phy_wait_end: got %0d expected 1", seqState); end
    stepTo(24);
    checks++; if (seqState !== 4'd2 || pmaReset !== 1'b1) begin errors++; $display("[TB] FAIL pma_start: got st=%0d pma=%b expected st=2 pma=1", seqState, pmaReset); end
    stepTo(27);
    checks++; if (seqState !== 4'd2 || pmaReset !== 1'b1) begin errors++; $display("[TB] FAIL pma_end: got st=%0d pma=%b expected st=2 pma=1", seqState, pmaReset); end
    stepTo(28);
    checks++; if (seqState !== 4'd3 || pmaReset !== 1'b0) begin errors++; $display("[TB] FAIL pma_release: got st=%0d pma=%b expected st=3 pma=0", seqState, pmaReset); end
    stepTo(40);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    stepTo(42);
    checks++; if (seqState !== 4'd3 || mmcmReset !== 1'b1) begin errors++; $display("[TB] FAIL done_sync_latency: got st=%0d mmcm=%b expected st=3 mmcm=1", seqState, mmcmReset); end
    stepTo(43);
    checks++; if (seqState !== 4'd4 || mmcmReset !== 1'b0) begin errors++; $display("[TB] FAIL wait_lock_entry: got st=%0d mmcm=%b expected st=4 mmcm=0", seqState, mmcmReset); end
    stepTo(50);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    stepTo(52);
    checks++; if (seqState !== 4'd4 || pcsReset !== 1'b1) begin errors++; $display("[TB] FAIL lock_sync_latency: got st=%0d pcs=%b expected st=4 pcs=1", seqState, pcsReset); end
    stepTo(53);
    checks++; if (seqState !== 4'd5 || pcsReset !== 1'b0) begin errors++; $display("[TB] FAIL wait_link_entry: got st=%0d pcs=%b expected st=5 pcs=0", seqState, pcsReset); end
    stepTo(60);
    applyStimulus(1'b1, 1'b1, 16'h0003);
    stepTo(69);
    checks++; if (linkUp !== 1'b0 || seqState !== 4'd5) begin errors++; $display("[TB] FAIL link_up_early: got up=%b st=%0d expected up=0 st=5", linkUp, seqState); end
    stepTo(70);
    checks++; if (linkUp !== 1'b1 || seqState !== 4'd6) begin errors++; $display("[TB] FAIL link_up_on_time: got up=%b st=%0d expected up=1 st=6", linkUp, seqState); end
  endtask

  task automatic test_link_flap;
    stepTo(80);
    applyStimulus(1'b1, 1'b1, 16'h0002);
    stepTo(81);
    applyStimulus(1'b1, 1'b1, 16'h0003);
    stepTo(82);
    checks++; if (linkUp !== 1'b1) begin errors++; $display("[TB] FAIL flap_before: got %b expected 1", linkUp); end
    stepTo(83);
    checks++; if (linkUp !== 1'b0 || seqState !== 4'd5) begin errors++; $display("[TB] FAIL flap_drop: got up=%b st=%0d expected up=0 st=5", linkUp, seqState); end
    checks++; if ({gmiiRstn, pmaReset, mmcmReset, pcsReset} !== 4'b1000) begin errors++; $display("[TB] FAIL flap_resets: got %b expected 1000", {gmiiRstn, pmaReset, mmcmReset, pcsReset}); end
    checks++; if (linkDrops !== DROPS_AFTER_FLAP) begin errors++; $display("[TB] FAIL flap_drops: got %0d expected %0d", linkDrops, DROPS_AFTER_FLAP); end
    stepTo(90);
    checks++; if (linkUp !== 1'b0) begin errors++; $display("[TB] FAIL flap_requalify_early: got %b expected 0", linkUp); end
    stepTo(91);
    checks++; if (linkUp !== 1'b1 || seqState !== 4'd6) begin errors++; $display("[TB] FAIL flap_requalify: got up=%b st=%0d expected up=1 st=6", linkUp, seqState); end
  endtask

  task automatic test_lock_loss;
    stepTo(100);
    applyStimulus(1'b1, 1'b0, 16'h0003);
    stepTo(102);
    checks++; if (seqState !== 4'd6 || linkUp !== 1'b1) begin errors++; $display("[TB] FAIL loss_latency: got st=%0d up=%b expected st=6 up=1", seqState, linkUp); end
    stepTo(103);
    checks++; if (seqState !== 4'd7 || linkUp !== 1'b0 || retryCnt !== 4'd0) begin errors++; $display("[TB] FAIL loss_retry: got st=%0d up=%b rc=%0d expected st=7 up=0 rc=0", seqState, linkUp, retryCnt); end
    stepTo(104);
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd1) begin errors++; $display("[TB] FAIL loss_restart_seq: got st=%0d rc=%0d expected st=0 rc=1", seqState, retryCnt); end
    checks++; if ({gmiiRstn, pmaReset, mmcmReset, pcsReset} !== 4'b0111) begin errors++; $display("[TB] FAIL loss_resets: got %b expected 0111", {gmiiRstn, pmaReset, mmcmReset, pcsReset}); end
    checks++; if (linkDrops !== DROPS_AFTER_LOSS) begin errors++; $display("[TB] FAIL loss_drops: got %0d expected %0d", linkDrops, DROPS_AFTER_LOSS); end
    stepTo(112);
    checks++; if (seqState !== 4'd1 || gmiiRstn !== 1'b1) begin errors++; $display("[TB] FAIL loss_phy_wait: got st=%0d gmii=%b expected st=1 gmii=1", seqState, gmiiRstn); end
  endtask

  task automatic test_never_lock;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    doReset();
    stepTo(92);
    checks++; if (seqState !== 4'd4) begin errors++; $display("[TB] FAIL nolock_wait: got %0d expected 4", seqState); end
    stepTo(93);
    checks++; if (seqState !== 4'd7 || retryCnt !== 4'd0) begin errors++; $display("[TB] FAIL nolock_retry1: got st=%0d rc=%0d expected st=7 rc=0", seqState, retryCnt); end
    stepTo(94);
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd1 || mmcmReset !== 1'b1) begin errors++; $display("[TB] FAIL nolock_attempt2: got st=%0d rc=%0d mmcm=%b expected st=0 rc=1 mmcm=1", seqState, retryCnt, mmcmReset); end
    stepTo(188);
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd2) begin errors++; $display("[TB] FAIL nolock_attempt3: got st=%0d rc=%0d expected st=0 rc=2", seqState, retryCnt); end
    stepTo(281);
    checks++; if (seqState !== 4'd7 || failOut !== 1'b0) begin errors++; $display("[TB] FAIL nolock_last_retry: got st=%0d fail=%b expected st=7 fail=0", seqState, failOut); end
    stepTo(282);
    checks++; if (seqState !== 4'd8 || failOut !== 1'b1 || retryCnt !== 4'd3) begin errors++; $display("[TB] FAIL nolock_fail: got st=%0d fail=%b rc=%0d expected st=8 fail=1 rc=3", seqState, failOut, retryCnt); end
    checks++; if ({gmiiRstn, pmaReset, mmcmReset, pcsReset} !== 4'b0111) begin errors++; $display("[TB] FAIL nolock_fail_resets: got %b expected 0111", {gmiiRstn, pmaReset, mmcmReset, pcsReset}); end
    stepTo(290);
    checks++; if (seqState !== 4'd8 || retryCnt !== 4'd3) begin errors++; $display("[TB] FAIL nolock_fail_sticky: got st=%0d rc=%0d expected st=8 rc=3", seqState, retryCnt); end
  endtask

  task automatic test_restart;
    restart = 1'b1;
    stepTo(291);
    restart = 1'b0;
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd0 || failOut !== 1'b0) begin errors++; $display("[TB] FAIL restart_from_fail: got st=%0d rc=%0d fail=%b expected st=0 rc=0 fail=0", seqState, retryCnt, failOut); end
    stepTo(298);
    checks++; if (seqState !== 4'd0 || gmiiRstn !== 1'b0) begin errors++; $display("[TB] FAIL restart_timer_reload: got st=%0d gmii=%b expected st=0 gmii=0", seqState, gmiiRstn); end
    stepTo(299);
    checks++; if (seqState !== 4'd1 || gmiiRstn !== 1'b1) begin errors++; $display("[TB] FAIL restart_phy_wait: got st=%0d gmii=%b expected st=1 gmii=1", seqState, gmiiRstn); end
    stepTo(300);
    applyStimulus(1'b1, 1'b1, 16'h0000);
    stepTo(321);
    checks++; if (seqState !== 4'd5) begin errors++; $display("[TB] FAIL restart_reach_wait_link: got %0d expected 5", seqState); end
    stepTo(330);
    restart = 1'b1;
    stepTo(331);
    restart = 1'b0;
    checks++; if (seqState !== 4'd0 || pcsReset !== 1'b1) begin errors++; $display("[TB] FAIL restart_mid_wait_link: got st=%0d pcs=%b expected st=0 pcs=1", seqState, pcsReset); end
    stepTo(424);
    checks++; if (seqState !== 4'd5) begin errors++; $display("[TB] FAIL link_timeout_last: got %0d expected 5", seqState); end
    stepTo(425);
    checks++; if (seqState !== 4'd7) begin errors++; $display("[TB] FAIL link_timeout_retry: got %0d expected 7", seqState); end
    stepTo(426);
    checks++; if (retryCnt !== 4'd1) begin errors++; $display("[TB] FAIL link_timeout_count: got %0d expected 1", retryCnt); end
    stepTo(519);
    checks++; if (seqState !== 4'd5) begin errors++; $display("[TB] FAIL second_timeout_state: got %0d expected 5", seqState); end
    restart = 1'b1;
    stepTo(520);
    restart = 1'b0;
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd0) begin errors++; $display("[TB] FAIL restart_at_expiry: got st=%0d rc=%0d expected st=0 rc=0", seqState, retryCnt); end
    stepTo(521);
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd0) begin errors++; $display("[TB] FAIL restart_at_expiry_hold: got st=%0d rc=%0d expected st=0 rc=0", seqState, retryCnt); end
  endtask

  task automatic test_sys_reset;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    doReset();
    stepTo(92);
    checks++; if (seqState !== 4'd7) begin errors++; $display("[TB] FAIL done_timeout_retry: got %0d expected 7", seqState); end
    stepTo(118);
    checks++; if (seqState !== 4'd2 || retryCnt !== 4'd1 || gmiiRstn !== 1'b1) begin errors++; $display("[TB] FAIL mid_pma: got st=%0d rc=%0d gmii=%b expected st=2 rc=1 gmii=1", seqState, retryCnt, gmiiRstn); end
    rst = 1'b1;
    stepTo(119);
    rst = 1'b0;
    checks++; if (seqState !== 4'd0 || retryCnt !== 4'd0 || gmiiRstn !== 1'b0) begin errors++; $display("[TB] FAIL sysrst_state: got st=%0d rc=%0d gmii=%b expected st=0 rc=0 gmii=0", seqState, retryCnt, gmiiRstn); end
    checks++; if ({pmaReset, mmcmReset, pcsReset, linkUp, failOut} !== 5'b11100 || linkDrops !== 16'd0) begin errors++; $display("[TB] FAIL sysrst_outputs: got %b drops=%0d expected 11100 drops=0", {pmaReset, mmcmReset, pcsReset, linkUp, failOut}, linkDrops); end
  endtask

  // Scenario sequence; each task leaves the DUT where the next one expects it
  initial begin
    test_reset();
    test_bring_up();
    test_link_flap();
    test_lock_loss();
    test_never_lock();
    test_restart();
    test_sys_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
